// File: rtl/mesh_router_param_if.sv
// Flit handshake and routing-table lookup bundle for mesh_router_param.
// slave is the router side; master is the environment side.
interface mesh_router_param_if #(
    parameter int PORTS    = 5,
    parameter int WIDTH    = 16,
    parameter int DIR_BITS = 3
);
    localparam int ACT_W = $clog2(PORTS + 1);

    logic [PORTS-1:0]       in_valid;
    logic [PORTS*WIDTH-1:0] in_data;
    logic [PORTS-1:0]       in_ready;
    logic [PORTS-1:0]       out_valid;
    logic [PORTS*WIDTH-1:0] out_data;
    logic [PORTS-1:0]       out_ready;
    logic [WIDTH-1:0]       table_addr;
    logic [DIR_BITS-1:0]    table_data;
    logic [ACT_W-1:0]       activity_level;

    modport slave (
        input  in_valid, in_data, out_ready, table_data,
        output in_ready, out_valid, out_data, table_addr, activity_level
    );

    modport master (
        output in_valid, in_data, out_ready, table_data,
        input  in_ready, out_valid, out_data, table_addr, activity_level
    );
endinterface

// File: rtl/mesh_router_param.sv
// Parametrised mesh router: per-port input FIFOs, round-robin switch allocator, one-flit output registers.
// Optional macro ROUTER_STATS_EN adds saturating fwd_count/drop_count outputs.
module mesh_router_param #(
    parameter int PORTS    = 5,
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 4,
    parameter int DIR_BITS = 3,
    parameter int ACT_HOLD = 3
) (
    input  logic               clk,
    input  logic               reset,
    mesh_router_param_if.slave bus
`ifdef ROUTER_STATS_EN
    ,
    output logic [15:0]        fwd_count,
    output logic [15:0]        drop_count
`endif
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;
    localparam int PW    = (PORTS > 1) ? $clog2(PORTS) : 1;
    localparam int ACT_W = $clog2(PORTS + 1);

    logic [WIDTH-1:0] fifo_mem [PORTS][DEPTH];
    logic [AW-1:0]    wr_ptr [PORTS];
    logic [AW-1:0]    rd_ptr [PORTS];
    logic [CW-1:0]    count [PORTS];
    logic [CW-1:0]    count_next [PORTS];
    logic [PORTS-1:0] push;
    logic [PORTS-1:0] pop;
    logic [PORTS-1:0] not_empty;
    logic [PW-1:0]    rr_ptr;
    logic [PW-1:0]    sel;
    logic             sel_valid;
    logic             dest_ok;
    logic             dest_free;
    logic             do_load;
    logic             do_drop;
    logic [WIDTH-1:0] head;
    logic [3:0]       act_cnt [PORTS];
    logic [ACT_W-1:0] act_sum;

    always_comb begin
        push      = '0;
        not_empty = '0;
        for (int i = 0; i < PORTS; i++) begin
            push[i]      = bus.in_valid[i] & bus.in_ready[i];
            not_empty[i] = (count[i] != '0);
        end
    end

    // Scan starts at rr_ptr so the input granted last cycle gets lowest priority.
    always_comb begin
        int idx;
        idx       = 0;
        sel       = '0;
        sel_valid = 1'b0;
        for (int k = 0; k < PORTS; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= PORTS) idx = idx - PORTS;
            if (!sel_valid && not_empty[idx]) begin
                sel       = PW'(idx);
                sel_valid = 1'b1;
            end
        end
    end

    assign head           = fifo_mem[sel][rd_ptr[sel]];
    assign bus.table_addr = sel_valid ? head : '0;

    always_comb begin
        dest_ok   = (int'(bus.table_data) < PORTS);
        dest_free = 1'b0;
        for (int j = 0; j < PORTS; j++) begin
            if (int'(bus.table_data) == j) dest_free = !bus.out_valid[j] | bus.out_ready[j];
        end
        do_load = sel_valid & dest_ok & dest_free;
        do_drop = sel_valid & !dest_ok;
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < PORTS; i++) begin
            pop[i]        = (do_load | do_drop) && (sel == PW'(i));
            count_next[i] = count[i];
            if (push[i] && !pop[i])      count_next[i] = count[i] + CW'(1);
            else if (!push[i] && pop[i]) count_next[i] = count[i] - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < PORTS; i++) begin
            if (push[i]) fifo_mem[i][wr_ptr[i]] <= bus.in_data[i*WIDTH +: WIDTH];
        end
    end

    // in_ready is registered from the post-edge occupancy, so a full FIFO never sees a push.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.in_ready <= '0;
            for (int i = 0; i < PORTS; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < PORTS; i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + AW'(1);
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + AW'(1);
                count[i]        <= count_next[i];
                bus.in_ready[i] <= (count_next[i] != CW'(DEPTH));
            end
        end
    end

    always_comb begin
        act_sum = '0;
        for (int j = 0; j < PORTS; j++) begin
            if (act_cnt[j] != 4'd0) act_sum = act_sum + ACT_W'(1);
        end
    end

    // A reload in the same cycle as a drain wins, keeping out_valid high with the new flit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr             <= '0;
            bus.out_valid      <= '0;
            bus.out_data       <= '0;
            bus.activity_level <= '0;
            for (int j = 0; j < PORTS; j++) act_cnt[j] <= 4'd0;
        end else begin
            if (sel_valid) rr_ptr <= (sel == PW'(PORTS - 1)) ? '0 : sel + PW'(1);
            bus.activity_level <= act_sum;
            for (int j = 0; j < PORTS; j++) begin
                if (do_load && (int'(bus.table_data) == j)) begin
                    bus.out_valid[j]               <= 1'b1;
                    bus.out_data[j*WIDTH +: WIDTH] <= head;
                end else if (bus.out_valid[j] && bus.out_ready[j]) begin
                    bus.out_valid[j] <= 1'b0;
                end
                if (bus.out_valid[j] && bus.out_ready[j]) act_cnt[j] <= 4'(ACT_HOLD);
                else if (act_cnt[j] != 4'd0)              act_cnt[j] <= act_cnt[j] - 4'd1;
            end
        end
    end

`ifdef ROUTER_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fwd_count  <= 16'd0;
            drop_count <= 16'd0;
        end else begin
            if (do_load && fwd_count != 16'hFFFF)  fwd_count  <= fwd_count + 16'd1;
            if (do_drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_mesh_router_param.sv
// Self-checking bench for mesh_router_param: table-driven single-flit routes plus
// hand-written round-robin, backpressure, streaming and asynchronous-reset sequences.
module tb_mesh_router_param;
    localparam int PORTS = 5;
    localparam int WIDTH = 16;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    mesh_router_param_if #(.PORTS(PORTS), .WIDTH(WIDTH), .DIR_BITS(3)) bus ();

`ifdef ROUTER_STATS_EN
    logic [15:0] fwd_count;
    logic [15:0] drop_count;
`endif

    mesh_router_param #(
        .PORTS(PORTS), .WIDTH(WIDTH), .DEPTH(4), .DIR_BITS(3), .ACT_HOLD(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
`ifdef ROUTER_STATS_EN
        ,
        .fwd_count(fwd_count),
        .drop_count(drop_count)
`endif
    );

    always #5 clk = ~clk;

    // Routing table: bits [10:8] name the output, with 0x0012 mapped to output 2.
    function automatic logic [2:0] route(input logic [15:0] addr);
        if (addr == 16'h0012) return 3'd2;
        return addr[10:8];
    endfunction

    always_comb bus.table_data = route(bus.table_addr);

    typedef struct {
        int          port;
        logic [15:0] data;
        logic [4:0]  exp_valid;
        int          exp_dest;
    } vec_t;

    vec_t vecs [7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int port, input logic valid, input logic [15:0] data);
        bus.in_valid[port]            = valid;
        bus.in_data[port*WIDTH +: 16] = data;
    endtask

    task automatic doReset();
        reset         = 1'b1;
        bus.in_valid  = '0;
        bus.in_data   = '0;
        bus.out_ready = '1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [4:0]  rr_valid [8];
        logic [15:0] rr_data  [8];
        int          rr_dest  [8];
        logic [2:0]  act_exp  [7];
        logic [4:0]  act_vld  [7];
        logic [15:0] drop_before;

        vecs[0] = '{4, 16'h0012, 5'b00100, 2};
        vecs[1] = '{0, 16'h0100, 5'b00010, 1};
        vecs[2] = '{1, 16'h0334, 5'b01000, 3};
        vecs[3] = '{3, 16'h0455, 5'b10000, 4};
        vecs[4] = '{2, 16'h00AB, 5'b00001, 0};
        vecs[5] = '{2, 16'h0777, 5'b00000, -1};
        vecs[6] = '{4, 16'h0561, 5'b00000, -1};

        bus.in_valid  = '0;
        bus.in_data   = '0;
        bus.out_ready = '1;

        // Reset values, then in_ready rising at the first edge after release.
        #1 reset = 1'b1;
        #1;
        checkOutput("rst_in_ready", 32'(bus.in_ready), 32'h0);
        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'h0);
        checkOutput("rst_out_data", 32'(bus.out_data[31:0]), 32'h0);
        checkOutput("rst_activity", 32'(bus.activity_level), 32'h0);
        checkOutput("rst_table_addr", 32'(bus.table_addr), 32'h0);
        tick();
        tick();
        reset = 1'b0;
        checkOutput("rst_in_ready_hold", 32'(bus.in_ready), 32'h0);
        tick();
        checkOutput("rst_in_ready_up", 32'(bus.in_ready), 32'h1F);

        // Single flit 0x0012 from port 4 to output 2, with the activity hold window.
        act_exp = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd0};
        act_vld = '{5'b00000, 5'b00100, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000};
        applyStimulus(4, 1'b1, 16'h0012);
        tick();
        applyStimulus(4, 1'b0, 16'h0000);
        for (int c = 0; c < 7; c++) begin
            checkOutput($sformatf("act_level_t%0d", c), 32'(bus.activity_level), 32'(act_exp[c]));
            checkOutput($sformatf("act_valid_t%0d", c), 32'(bus.out_valid), 32'(act_vld[c]));
            if (c == 1) checkOutput("act_data", 32'(bus.out_data[2*WIDTH +: 16]), 32'h0012);
            tick();
        end

        // Table-driven single-flit routes, including drops for table_data >= PORTS.
        for (int v = 0; v < 7; v++) begin
`ifdef ROUTER_STATS_EN
            drop_before = drop_count;
`else
            drop_before = 16'd0;
`endif
            applyStimulus(vecs[v].port, 1'b1, vecs[v].data);
            tick();
            applyStimulus(vecs[v].port, 1'b0, 16'h0000);
            checkOutput($sformatf("vec%0d_table_addr", v), 32'(bus.table_addr), 32'(vecs[v].data));
            tick();
            checkOutput($sformatf("vec%0d_out_valid", v), 32'(bus.out_valid), 32'(vecs[v].exp_valid));
            checkOutput($sformatf("vec%0d_popped", v), 32'(bus.table_addr), 32'h0);
            if (vecs[v].exp_dest >= 0)
                checkOutput($sformatf("vec%0d_out_data", v),
                            32'(bus.out_data[vecs[v].exp_dest*WIDTH +: 16]), 32'(vecs[v].data));
`ifdef ROUTER_STATS_EN
            else
                checkOutput($sformatf("vec%0d_drop_count", v), 32'(drop_count), 32'(drop_before) + 32'd1);
`endif
            tick();
            checkOutput($sformatf("vec%0d_drained", v), 32'(bus.out_valid), 32'h0);
            tick();
            tick();
        end

        // Round robin over ports 0,1,3 with two flits each.
        doReset();
        rr_valid = '{5'b00010, 5'b00100, 5'b10000, 5'b00010, 5'b00100, 5'b10000, 5'b00000, 5'b00000};
        rr_data  = '{16'h0110, 16'h0220, 16'h0440, 16'h0111, 16'h0221, 16'h0441, 16'h0, 16'h0};
        rr_dest  = '{1, 2, 4, 1, 2, 4, -1, -1};
        applyStimulus(0, 1'b1, 16'h0110);
        applyStimulus(1, 1'b1, 16'h0220);
        applyStimulus(3, 1'b1, 16'h0440);
        tick();
        applyStimulus(0, 1'b1, 16'h0111);
        applyStimulus(1, 1'b1, 16'h0221);
        applyStimulus(3, 1'b1, 16'h0441);
        tick();
        bus.in_valid = '0;
        for (int g = 0; g < 7; g++) begin
            checkOutput($sformatf("rr_valid_g%0d", g), 32'(bus.out_valid), 32'(rr_valid[g]));
            if (rr_dest[g] >= 0)
                checkOutput($sformatf("rr_data_g%0d", g), 32'(bus.out_data[rr_dest[g]*WIDTH +: 16]), 32'(rr_data[g]));
            tick();
        end

        // Back-to-back stream from port 0 to output 1 with no bubbles.
        doReset();
        for (int k = 0; k < 6; k++) begin
            applyStimulus(0, 1'b1, 16'h0150 + 16'(k));
            tick();
            if (k > 0) begin
                checkOutput($sformatf("b2b_valid_%0d", k), 32'(bus.out_valid[1]), 32'h1);
                checkOutput($sformatf("b2b_data_%0d", k), 32'(bus.out_data[WIDTH +: 16]), 32'h0150 + 32'(k - 1));
            end
        end
        applyStimulus(0, 1'b0, 16'h0000);
        tick();
        checkOutput("b2b_last_data", 32'(bus.out_data[WIDTH +: 16]), 32'h0155);
        tick();
        checkOutput("b2b_idle", 32'(bus.out_valid), 32'h0);

        // Output 2 held off: port 0 fills, port 1 to output 3 forwards every other cycle.
        doReset();
        bus.out_ready[2] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            checkOutput($sformatf("bp_ready_before_%0d", k), 32'(bus.in_ready[0]), 32'h1);
            applyStimulus(0, 1'b1, 16'h02A0 + 16'(k));
            tick();
        end
        applyStimulus(0, 1'b0, 16'h0000);
        checkOutput("bp_in_ready_low", 32'(bus.in_ready[0]), 32'h0);
        checkOutput("bp_out2_valid", 32'(bus.out_valid[2]), 32'h1);
        checkOutput("bp_out2_data", 32'(bus.out_data[2*WIDTH +: 16]), 32'h02A0);
        for (int s = 0; s < 7; s++) begin
            if (s < 3) applyStimulus(1, 1'b1, 16'h03B0 + 16'(s));
            else       applyStimulus(1, 1'b0, 16'h0000);
            tick();
            if (s > 0) begin
                checkOutput($sformatf("bp_out3_valid_s%0d", s), 32'(bus.out_valid[3]), (s % 2 == 1) ? 32'h1 : 32'h0);
                if (s % 2 == 1)
                    checkOutput($sformatf("bp_out3_data_s%0d", s), 32'(bus.out_data[3*WIDTH +: 16]), 32'h03B0 + 32'(s / 2));
            end
        end
        checkOutput("bp_in_ready_still_low", 32'(bus.in_ready[0]), 32'h0);

        // Asynchronous reset with several FIFOs and output registers occupied.
        bus.out_ready = '0;
        applyStimulus(1, 1'b1, 16'h0360);
        applyStimulus(3, 1'b1, 16'h0470);
        applyStimulus(4, 1'b1, 16'h0280);
        tick();
        applyStimulus(1, 1'b1, 16'h0361);
        applyStimulus(3, 1'b1, 16'h0471);
        applyStimulus(4, 1'b1, 16'h0281);
        tick();
        bus.in_valid = '0;
        tick();
        tick();
        checkOutput("ar_pre_valid", 32'(bus.out_valid), 32'h1C);
        #2 reset = 1'b1;
        #1;
        checkOutput("ar_out_valid", 32'(bus.out_valid), 32'h0);
        checkOutput("ar_in_ready", 32'(bus.in_ready), 32'h0);
        checkOutput("ar_activity", 32'(bus.activity_level), 32'h0);
        checkOutput("ar_table_addr", 32'(bus.table_addr), 32'h0);
        bus.out_ready = '1;
        tick();
        reset = 1'b0;
        for (int r = 0; r < 6; r++) begin
            tick();
            checkOutput($sformatf("ar_no_stale_valid_%0d", r), 32'(bus.out_valid), 32'h0);
            checkOutput($sformatf("ar_no_stale_addr_%0d", r), 32'(bus.table_addr), 32'h0);
        end
        checkOutput("ar_in_ready_up", 32'(bus.in_ready), 32'h1F);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
